dec_scan_nx: RTL



---
 rtl/dec_scan_nx.sv | 108 ++++++++++
 1 files changed

// File: rtl/dec_scan_nx.sv
// Registered N-to-2^N one-hot select decoder with a direct-load mode and a
// masked scan mode that walks the active line with a programmable dwell.
module dec_scan_nx #(
  parameter int N              = 3,
  parameter int DWELL          = 4,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                load,
  input  logic [N-1:0]        sel,
  input  logic [(1<<N)-1:0]   skip,
  output logic [(1<<N)-1:0]   out,
  output logic [N-1:0]        idx,
  output logic                active,
  output logic                wrap
);

  localparam int unsigned    LINES    = 1 << N;
  localparam int             CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);

  localparam logic [0:0] ST_DIRECT = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  logic [0:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N-1:0]     idx_n;
  logic [N-1:0]     nxt;
  logic [N-1:0]     cand;
  logic             found;
  logic             active_n;
  logic             wrap_n;
  logic [LINES-1:0] out_n;

  // First unmasked line after idx in circular order; idx itself is tried last.
  always_comb begin
    nxt   = idx;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= LINES; k++) begin
      cand = idx + N'(k);
      if (!found && !skip[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    active_n = active;
    wrap_n   = 1'b0;
    if (!en) begin
      active_n = 1'b0;
    end else if (!mode) begin
      state_n = ST_DIRECT;
      if (load) begin
        idx_n    = sel;
        active_n = 1'b1;
      end
    end else if (state == ST_DIRECT) begin
      state_n  = ST_SCAN;
      cnt_n    = '0;
      active_n = !skip[idx];
    end else begin
      if (cnt == CNT_LAST) begin
        cnt_n  = '0;
        idx_n  = nxt;
        wrap_n = found && (nxt <= idx);
      end else begin
        cnt_n = cnt + CW'(1);
      end
      active_n = !skip[idx_n];
    end
  end

  // The bus is decoded from next-state values so it registers alongside idx/active.
  always_comb begin
    out_n = '0;
    for (int unsigned k = 0; k < LINES; k++) begin
      out_n[k] = (active_n && (idx_n == N'(k))) ^ OUT_ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_DIRECT;
      cnt    <= '0;
      idx    <= '0;
      active <= 1'b0;
      wrap   <= 1'b0;
      out    <= OUT_ACTIVE_LOW ? '1 : '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      active <= active_n;
      wrap   <= wrap_n;
      out    <= out_n;
    end
  end

endmodule
